// File: rtl/cpu_hazard_scoreboard.sv
// cpu_hazard_scoreboard
// Per-register countdown scoreboard for the ID stage. Each GPR carries the
// number of bubbles a dependent still has to wait before the producer's
// value can be forwarded. A new producer loads its latency. Every free-running
// cycle counts the pending entries down. A freeze keeps them as they are, and
// a flush clears them.
module cpu_hazard_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int NUM_READ = 2,
    parameter int MAX_LAT  = 4,
    localparam int LAT_W   = $clog2(MAX_LAT + 1),
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic                           hold,
    input  logic                           issue_valid,
    input  logic                           issue_we,
    input  logic [AW-1:0]                  issue_waddr,
    input  logic [LAT_W-1:0]               issue_lat,
    input  logic [NUM_READ-1:0][AW-1:0]    raddr,
    output logic                           stall_req,
    output logic [NUM_READ-1:0][LAT_W-1:0] port_wait,
    output logic [NUM_REGS-1:0]            busy
);

    localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(MAX_LAT);
    localparam logic [LAT_W-1:0] LAT_ONE = LAT_W'(1);
    localparam logic [LAT_W-1:0] LAT_ZERO = {LAT_W{1'b0}};

    logic [NUM_REGS-1:0][LAT_W-1:0] cnt_q;
    logic [NUM_REGS-1:0][LAT_W-1:0] cnt_d;
    logic [NUM_REGS-1:0]            busy_q;
    logic [NUM_REGS-1:0]            busy_d;
    logic [NUM_READ-1:0]            hazard_s;
    logic [LAT_W-1:0]               lat_clamp_s;
    logic                           accept_s;

    // Hazard lookup per read port; r0 and out-of-range addresses never wait.
    always_comb begin
        hazard_s  = {NUM_READ{1'b0}};
        port_wait = {(NUM_READ*LAT_W){1'b0}};
        for (int p = 0; p < NUM_READ; p++) begin
            if ((raddr[p] != {AW{1'b0}}) && (int'(raddr[p]) < NUM_REGS)) begin
                port_wait[p] = cnt_q[raddr[p]];
                hazard_s[p]  = (cnt_q[raddr[p]] != LAT_ZERO);
            end else begin
                port_wait[p] = LAT_ZERO;
                hazard_s[p]  = 1'b0;
            end
        end
        stall_req = |hazard_s;
    end

    // Issue acceptance and latency clamp for the incoming producer.
    always_comb begin
        accept_s = issue_valid & ~stall_req & ~hold & ~flush;
        if (issue_lat > LAT_MAX) begin
            lat_clamp_s = LAT_MAX;
        end else begin
            lat_clamp_s = issue_lat;
        end
    end

    // Next counter values: flush clears, hold freezes, else count down with
    // an accepted write taking precedence over the decrement of its register.
    always_comb begin
        cnt_d  = {(NUM_REGS*LAT_W){1'b0}};
        busy_d = {NUM_REGS{1'b0}};
        for (int r = 0; r < NUM_REGS; r++) begin
            if (r == 0) begin
                cnt_d[r] = LAT_ZERO;
            end else if (flush) begin
                cnt_d[r] = LAT_ZERO;
            end else if (hold) begin
                cnt_d[r] = cnt_q[r];
            end else if (accept_s && issue_we && (issue_waddr == AW'(r))) begin
                cnt_d[r] = lat_clamp_s;
            end else if (cnt_q[r] != LAT_ZERO) begin
                cnt_d[r] = cnt_q[r] - LAT_ONE;
            end else begin
                cnt_d[r] = LAT_ZERO;
            end
            busy_d[r] = (cnt_d[r] != LAT_ZERO);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= {(NUM_REGS*LAT_W){1'b0}};
            busy_q <= {NUM_REGS{1'b0}};
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: doc/cpu_hazard_scoreboard.md
# cpu_hazard_scoreboard

Parametrised register-hazard scoreboard for the ID stage. It replaces the fixed "one-cycle load-use" stall rule with per-register countdown counters, so it can track producers of any latency up to MAX_LAT: loads, multi-cycle MUL/DIV, and coprocessor moves. It sits beside the decoder. The decoder presents its source register addresses and the destination/latency of the instruction being issued; the scoreboard returns a stall request and per-port wait information. Operand forwarding from EX/MEM stays in the decoder; the scoreboard only decides when a forwardable value does not exist yet.

## Interface
Parameters:
- NUM_REGS, 32, number of architectural GPRs; register 0 is hard-wired zero.
- NUM_READ, 2, number of source read ports checked per cycle.
- MAX_LAT, 4, largest accepted latency in bubbles; LAT_W = $clog2(MAX_LAT+1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  kill all in-flight producers (exception/eret); clears the scoreboard.
- hold  in  1  whole-pipeline freeze (memory wait); counters do not advance.
- issue_valid  in  1  the ID instruction leaves ID this cycle if stall_req=0.
- issue_we  in  1  the issued instruction writes a GPR.
- issue_waddr  in  $clog2(NUM_REGS)  destination register.
- issue_lat  in  LAT_W  number of bubbles a dependent must wait (0 = ALU, 1 = load, ...).
- raddr  in  NUM_READ x $clog2(NUM_REGS)  source registers of the ID instruction.
- stall_req  out  1  ID must hold; combinational from state and raddr.
- port_wait  out  NUM_READ x LAT_W  remaining bubbles for each port; 0 when no hazard.
- busy  out  NUM_REGS  registered; bit r set while cnt[r] != 0.

## Operation
- State: cnt[r] (LAT_W bits) per register r = 1..NUM_REGS-1. cnt[0] is constant 0.
- Hazard on port p: raddr[p] != 0 and cnt[raddr[p]] != 0. Then port_wait[p] = cnt[raddr[p]].
- stall_req = OR of the hazards on all ports. It uses the current state only; the instruction's own issue this cycle is not visible to its own reads.
- Accept = issue_valid & ~stall_req & ~hold & ~flush.
- Per-cycle update, in priority order:
  1. rst or flush: every cnt = 0.
  2. hold: no change.
  3. Otherwise, decrement every nonzero cnt, saturating at 0.
  4. If accept & issue_we & issue_waddr != 0, then cnt[issue_waddr] = min(issue_lat, MAX_LAT). This overrides the decrement for that register.
- WAW: a newer producer to a pending register overwrites its counter with the new latency, even if the new latency is smaller.
- issue_lat = 0 records nothing effective; the register stays or becomes 0.
- An issue with issue_we=0 or issue_waddr=0 never changes state.
- busy[r] = (cnt[r] != 0) after the update. busy[0] is always 0.

## Timing
- Reset: all cnt = 0, busy = 0. Hence stall_req = 0 and port_wait = 0 in the cycle after reset.
- A producer accepted in cycle T with latency L (L ≥ 1):
  - A dependent in ID at cycles T+1 .. T+L sees stall_req = 1, with port_wait = L, L-1, ..., 1.
  - At T+L+1 the dependent proceeds.
  - Example: a load (L=1) produces exactly one bubble.
- hold extends the stall window one cycle per held cycle; counters resume on release.
- flush in cycle T: state is clear from T+1, regardless of a simultaneous issue.
- stall_req has zero latency from raddr (combinational). busy has a one-cycle latency (registered).
- Reset mid-operation: pending counters are discarded; no stale stall after rst deasserts.

## Test plan
- Load-use: issue waddr=5, lat=1 at T; raddr[0]=5 at T+1 -> stall_req=1, port_wait[0]=1. At T+2 -> stall_req=0, busy[5]=0.
- DIV latency: issue waddr=8, lat=4; raddr[1]=8 held -> stall_req high for exactly 4 cycles, port_wait 4,3,2,1. With hold=1 for 2 of those cycles -> 6 stall cycles.
- WAW overwrite: issue r3 lat=4, then the next cycle issue r3 lat=1 -> cnt[3]=1, and a dependent stalls one cycle only.
- Zero/invalid: issue waddr=0 lat=3 -> busy stays 0. raddr=0 never stalls. issue_lat=7 with MAX_LAT=4 -> cnt clamps to 4.
- Flush race: r7 pending with cnt=3; flush and a new issue to r9 in the same cycle -> next cycle busy=0, stall_req=0.
- Two ports, different counts: r2 cnt=1, r4 cnt=3; raddr={2,4} -> stall_req=1, port_wait={1,3}. After 1 cycle -> {0,2}. After 3 cycles -> released.
